dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter HIT_BUF_EN, default 1, which enables the one-word read-hit buffer; when 0, every load goes downstream.
REQ-002 The block SHALL use one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 d_cache_addr  input  32  request byte address; bits [1:0] ignored, word address = addr[31:2].
REQ-006 d_cache_rmask  input  4  byte read mask; nonzero marks a load request.
REQ-007 d_cache_wmask  input  4  byte write mask; nonzero marks a store request.
REQ-008 d_cache_wdata  input  32  store data, already lane-aligned.
REQ-009 d_cache_rdata  output  32  registered full-word read data, valid only while d_cache_resp=1.
REQ-010 d_cache_resp  output  1  registered one-cycle completion pulse.
REQ-011 mem_addr  output  32  downstream word-aligned address ({word addr, 2'b00}).
REQ-012 mem_read / mem_write  output  1 each  downstream request strobes, held high until mem_resp.
REQ-013 mem_wmask  output  4 and mem_wdata  output  32  downstream store byte mask and store data.
REQ-014 mem_rdata  input  32  downstream read data, valid with mem_resp.
REQ-015 mem_resp  input  1  downstream completion pulse.

Function
REQ-016 The block SHALL treat a request as present when |rmask or |wmask; if both masks are nonzero, it SHALL treat the request as a store and ignore rmask.
REQ-017 The block SHALL accept requests that the initiator holds stable (addr/masks/wdata) until d_cache_resp, and that may be withdrawn or changed without warning (flush).
REQ-018 The FSM SHALL have states IDLE, WAIT and RESP; all outputs SHALL be registered.
REQ-019 IDLE, no request: remain IDLE, all strobes 0.
REQ-020 IDLE, load hit (HIT_BUF_EN, buf_valid, buf_waddr==addr[31:2]): latch request, load rdata from the buffer, go to RESP; the hit latency is request cycle T -> d_cache_resp at T+1.
REQ-021 IDLE, load miss or store: latch addr/masks/wdata, assert mem_read or mem_write (with mem_addr, mem_wmask, mem_wdata) from T+1, go to WAIT.
REQ-022 WAIT: hold all downstream outputs stable until mem_resp; on mem_resp, deassert strobes next cycle and go to RESP.
REQ-023 On a load mem_resp, the block SHALL capture rdata=mem_rdata, write buf_data=mem_rdata and buf_waddr=latched word addr, and set buf_valid.
REQ-024 On a store mem_resp, the block SHALL set rdata=0; if buf_valid and buf_waddr matches, it SHALL merge the wdata bytes selected by wmask into buf_data (write-through coherence).
REQ-025 The miss latency SHALL be mem_resp at cycle M -> d_cache_resp at M+1, and the total SHALL be T+2+k for a k-cycle downstream latency.
REQ-026 RESP: d_cache_resp=1 for exactly one cycle only if the current input request equals the latched request (word addr, rmask, wmask); otherwise the response SHALL be suppressed. The block SHALL always return to IDLE next cycle.
REQ-027 A request withdrawn or changed during WAIT SHALL NOT abort the downstream transaction; a store SHALL still complete downstream, and the buffer update SHALL still occur.
REQ-028 After RESP, a new request (even if identical to the previous one) SHALL be serviced from IDLE with no lost cycle beyond REQ-020/021 latency; the block SHALL never give back-to-back d_cache_resp.
REQ-029 mem_resp outside WAIT SHALL be ignored.

Reset
REQ-030 While rst_n=0, the block SHALL hold: state IDLE, d_cache_resp=0, d_cache_rdata=0, mem_read=mem_write=0, mem_addr=0, mem_wmask=0, mem_wdata=0, buf_valid=0.
REQ-031 Reset mid-WAIT SHALL drop strobes immediately (asynchronously) and discard the transaction; no d_cache_resp SHALL follow.

Verification
REQ-032 Load miss: rmask=4'b1111, addr=0x100, mem_resp after 3 cycles with 0xDEADBEEF -> mem_read high cycles T+1..T+4, d_cache_resp at T+5, rdata=0xDEADBEEF.
REQ-033 Load hit: repeat the load to 0x102, rmask=4'b0100 -> no mem_read, d_cache_resp at T+1, rdata=0xDEADBEEF.
REQ-034 Store merge: sb with wmask=4'b0010, wdata=0x0000AA00 to 0x100, then a load to 0x100 -> mem_write once, mem_wmask=4'b0010, the load hits with rdata=0xDEADAAEF.
REQ-035 Flush: load miss to 0x200, then masks go to 0 during WAIT -> mem_read held until mem_resp, no d_cache_resp, buffer holds 0x200 data.
REQ-036 Reset mid-WAIT: rst_n low during a store -> mem_write=0 immediately, buf_valid=0, no d_cache_resp after reset release.
REQ-037 HIT_BUF_EN=0: a repeated load to the same word -> mem_read issued both times.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-side memory responder: bridges a held-request data-cache port to a
// strobe/response downstream memory, with an optional one-word read-hit buffer.
module dmem_responder #(
    parameter bit HIT_BUF_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_cache_addr_i,
    input  logic [3:0]  d_cache_rmask_i,
    input  logic [3:0]  d_cache_wmask_i,
    input  logic [31:0] d_cache_wdata_i,
    output logic [31:0] d_cache_rdata_o,
    output logic        d_cache_resp_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_resp_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  rmask_q, rmask_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_q, resp_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        buf_valid_q, buf_valid_d;
    logic [29:0] buf_waddr_q, buf_waddr_d;
    logic [31:0] buf_data_q, buf_data_d;

    logic        req_store_s;
    logic        req_load_s;
    logic        req_hit_s;
    logic        req_match_s;
    logic        unused_addr_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign unused_addr_s = ^d_cache_addr_i[1:0];

    // Request classification; a nonzero write mask always wins over the read mask.
    always_comb begin
        req_store_s = (d_cache_wmask_i != 4'b0000);
        req_load_s  = (d_cache_rmask_i != 4'b0000) && !req_store_s;
        req_hit_s   = HIT_BUF_EN && req_load_s && buf_valid_q &&
                      (buf_waddr_q == d_cache_addr_i[31:2]);
        req_match_s = (d_cache_addr_i[31:2] == waddr_q) &&
                      (d_cache_rmask_i == rmask_q) &&
                      (d_cache_wmask_i == wmask_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        rmask_d     = rmask_q;
        wmask_d     = wmask_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        resp_d      = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_wmask_d = mem_wmask_q;
        mem_wdata_d = mem_wdata_q;
        buf_valid_d = buf_valid_q;
        buf_waddr_d = buf_waddr_q;
        buf_data_d  = buf_data_q;
        case (state_q)
            IDLE: begin
                if (req_store_s || req_load_s) begin
                    waddr_d = d_cache_addr_i[31:2];
                    rmask_d = d_cache_rmask_i;
                    wmask_d = d_cache_wmask_i;
                    wdata_d = d_cache_wdata_i;
                    if (req_hit_s) begin
                        rdata_d = buf_data_q;
                        resp_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        mem_addr_d  = {d_cache_addr_i[31:2], 2'b00};
                        mem_read_d  = !req_store_s;
                        mem_write_d = req_store_s;
                        mem_wmask_d = req_store_s ? d_cache_wmask_i : 4'b0000;
                        mem_wdata_d = d_cache_wdata_i;
                        state_d     = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (mem_resp_i) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    // The downstream result always lands; only the upstream pulse
                    // depends on the initiator still asking for the same thing.
                    resp_d      = req_match_s;
                    state_d     = RESP;
                    if (wmask_q != 4'b0000) begin
                        rdata_d = 32'h0000_0000;
                        if (buf_valid_q && (buf_waddr_q == waddr_q)) begin
                            buf_data_d = merge_bytes(buf_data_q, wdata_q, wmask_q);
                        end else begin
                            buf_data_d = buf_data_q;
                        end
                    end else begin
                        rdata_d     = mem_rdata_i;
                        buf_data_d  = mem_rdata_i;
                        buf_waddr_d = waddr_q;
                        buf_valid_d = HIT_BUF_EN;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waddr_q     <= 30'h0;
            rmask_q     <= 4'h0;
            wmask_q     <= 4'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            resp_q      <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wmask_q <= 4'h0;
            mem_wdata_q <= 32'h0;
            buf_valid_q <= 1'b0;
            buf_waddr_q <= 30'h0;
            buf_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            rmask_q     <= rmask_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
            buf_valid_q <= buf_valid_d;
            buf_waddr_q <= buf_waddr_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign d_cache_rdata_o = rdata_q;
    assign d_cache_resp_o  = resp_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign mem_wmask_o     = mem_wmask_q;
    assign mem_wdata_o     = mem_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a word-array memory model serves the
// downstream side and predicts every upstream response, hit or miss.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata, m_addr, m_wdata, m_rdata;
    logic [3:0]  rmask, wmask, m_wmask;
    logic        resp, m_read, m_write, m_resp;

    logic [31:0] nb_addr, nb_wdata, nb_rdata, nb_maddr, nb_mwdata;
    logic [3:0]  nb_rmask, nb_wmask, nb_mwmask;
    logic        nb_resp, nb_mread, nb_mwrite, nb_mresp;

    dmem_responder #(.HIT_BUF_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_cache_addr_i(addr), .d_cache_rmask_i(rmask), .d_cache_wmask_i(wmask),
        .d_cache_wdata_i(wdata), .d_cache_rdata_o(rdata), .d_cache_resp_o(resp),
        .mem_addr_o(m_addr), .mem_read_o(m_read), .mem_write_o(m_write),
        .mem_wmask_o(m_wmask), .mem_wdata_o(m_wdata),
        .mem_rdata_i(m_rdata), .mem_resp_i(m_resp)
    );

    dmem_responder #(.HIT_BUF_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .d_cache_addr_i(nb_addr), .d_cache_rmask_i(nb_rmask), .d_cache_wmask_i(nb_wmask),
        .d_cache_wdata_i(nb_wdata), .d_cache_rdata_o(nb_rdata), .d_cache_resp_o(nb_resp),
        .mem_addr_o(nb_maddr), .mem_read_o(nb_mread), .mem_write_o(nb_mwrite),
        .mem_wmask_o(nb_mwmask), .mem_wdata_o(nb_mwdata),
        .mem_rdata_i(32'h1234_5678), .mem_resp_i(nb_mresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference state: backing memory plus which word the hit buffer should hold.
    logic [31:0] mem [0:255];
    bit          ref_buf_valid;
    logic [29:0] ref_buf_w;

    // Downstream memory model.
    int          fixed_lat = -1;
    bit          spurious_en = 1'b0;
    bit          busy = 1'b0, real_resp = 1'b0, cur_write = 1'b0;
    int          cnt, lat, strobe_cycles, resp_cyc = 0, txn_count = 0;
    logic [7:0]  cur_w;
    logic [3:0]  cur_wm;
    logic [31:0] cur_wd;
    logic        exp_m_read;
    logic [31:0] exp_m_addr, exp_m_wdata;
    logic [3:0]  exp_m_wmask;

    initial begin : downstream
        m_resp  = 1'b0;
        m_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                busy = 1'b0; m_resp = 1'b0; real_resp = 1'b0;
            end else begin
                if (real_resp) begin
                    check("strobe_drop", {30'h0, m_read, m_write}, 32'h0);
                    real_resp = 1'b0;
                end
                m_resp = 1'b0;
                if (busy) begin
                    strobe_cycles++;
                    check("strobe_held", {30'h0, m_read, m_write}, {30'h0, !cur_write, cur_write});
                    check("mem_addr_hold", m_addr, {22'h0, cur_w, 2'b00});
                    if (cnt == 0) begin
                        busy = 1'b0; real_resp = 1'b1; m_resp = 1'b1; resp_cyc = cyc;
                        if (cur_write) begin
                            for (int i = 0; i < 4; i++)
                                if (cur_wm[i]) mem[cur_w][8*i +: 8] = cur_wd[8*i +: 8];
                            m_rdata = $urandom;
                        end else begin
                            m_rdata = mem[cur_w];
                        end
                        check("strobe_cycles", strobe_cycles, lat + 2);
                    end else begin
                        cnt--;
                    end
                end else if (m_read || m_write) begin
                    busy = 1'b1; txn_count++; strobe_cycles = 1;
                    lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
                    cnt = lat;
                    cur_write = m_write; cur_w = m_addr[9:2]; cur_wm = m_wmask; cur_wd = m_wdata;
                    check("mem_op", {30'h0, m_read, m_write}, {30'h0, exp_m_read, !exp_m_read});
                    check("mem_addr", m_addr, exp_m_addr);
                    check("mem_wmask", {28'h0, m_wmask}, {28'h0, exp_m_wmask});
                    if (!exp_m_read) check("mem_wdata", m_wdata, exp_m_wdata);
                end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                    m_resp = 1'b1; m_rdata = $urandom;
                end
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        bit          hit;
        int          issue_cyc;
        int          txn;
    } exp_t;
    exp_t        sbq[$];
    logic [31:0] last_rdata = 32'h0;
    bit          prev_resp = 1'b0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (resp === 1'b1) begin
                check("no_back_to_back", {31'h0, prev_resp}, 32'h0);
                if (sbq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_resp: got d_cache_resp=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("rdata", rdata, e.rdata);
                    if (e.hit) begin
                        check("hit_latency", cyc, e.issue_cyc + 1);
                        check("hit_no_mem", txn_count, e.txn);
                    end else begin
                        check("miss_latency", cyc, resp_cyc + 1);
                        check("miss_one_mem", txn_count, e.txn + 1);
                    end
                    last_rdata = rdata;
                end
            end
            prev_resp = (resp === 1'b1);
        end
    end

    // Issue one request; called #1 after a rising edge while the DUT is idle.
    task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                          input logic [31:0] wd, input bit flush_in);
        exp_t e;
        bit   store, hit, flush, seen;
        logic [29:0] w;
        store = (wm != 4'h0);
        w     = a[31:2];
        hit   = !store && ref_buf_valid && (ref_buf_w == w);
        flush = flush_in && !hit;
        e.hit = hit; e.issue_cyc = cyc; e.txn = txn_count;
        e.rdata = store ? 32'h0 : mem[w[7:0]];
        exp_m_read = !store; exp_m_addr = {w, 2'b00};
        exp_m_wmask = store ? wm : 4'h0; exp_m_wdata = wd;
        if (!store) begin
            ref_buf_valid = 1'b1; ref_buf_w = w;
        end
        addr = a; rmask = rm; wmask = wm; wdata = wd;
        if (!flush) begin
            sbq.push_back(e);
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(posedge clk); #1;
                seen = (resp === 1'b1);
            end
            if (!seen) begin
                vectors++; miscompares++;
                $display("FAIL resp_timeout: got no d_cache_resp, expected one for addr %h", a);
                void'(sbq.pop_back());
            end
            rmask = 4'h0; wmask = 4'h0;
        end else begin
            @(posedge clk); #1;
            rmask = 4'h0; wmask = 4'h0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(posedge clk); #1;
                seen = !busy && !m_read && !m_write;
            end
            if (!seen) begin
                vectors++; miscompares++;
                $display("FAIL flush_timeout: got strobes still high, expected completion for addr %h", a);
            end
            repeat (2) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
    endtask

    int nb_reads = 0;
    bit nb_pending = 1'b0;

    initial begin : nb_downstream
        nb_mresp = 1'b0;
        forever begin
            @(posedge clk); #1;
            nb_mresp = 1'b0;
            if (nb_pending) begin
                nb_mresp = 1'b1; nb_pending = 1'b0;
            end else if (nb_mread || nb_mwrite) begin
                nb_pending = 1'b1;
                if (nb_mread) nb_reads++;
            end
        end
    end

    task automatic nb_load();
        bit seen;
        nb_addr = 32'h0000_0100; nb_rmask = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (nb_resp === 1'b1);
        end
        check("nb_resp_seen", {31'h0, seen}, 32'h1);
        check("nb_rdata", nb_rdata, 32'h1234_5678);
        nb_rmask = 4'h0;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] a;
        logic [3:0]  rm, wm;
        int          r;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h40] = 32'hDEAD_BEEF;
        ref_buf_valid = 1'b0; ref_buf_w = 30'h0;
        rst_n = 1'b0; addr = 32'h0; rmask = 4'h0; wmask = 4'h0; wdata = 32'h0;
        nb_addr = 32'h0; nb_rmask = 4'h0; nb_wmask = 4'h0; nb_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp", {31'h0, resp}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_read", {31'h0, m_read}, 32'h0);
        check("rst_mem_write", {31'h0, m_write}, 32'h0);
        check("rst_mem_addr", m_addr, 32'h0);
        check("rst_mem_wmask", {28'h0, m_wmask}, 32'h0);
        check("rst_mem_wdata", m_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fixed_lat = 2;
        do_req(32'h0000_0100, 4'hF, 4'h0, 32'h0, 1'b0);
        check("miss_deadbeef", last_rdata, 32'hDEAD_BEEF);
        do_req(32'h0000_0102, 4'b0100, 4'h0, 32'h0, 1'b0);
        check("hit_deadbeef", last_rdata, 32'hDEAD_BEEF);
        do_req(32'h0000_0100, 4'h0, 4'b0010, 32'h0000_AA00, 1'b0);
        check("store_rdata_zero", last_rdata, 32'h0);
        do_req(32'h0000_0100, 4'hF, 4'h0, 32'h0, 1'b0);
        check("merge_hit", last_rdata, 32'hDEAD_AAEF);
        do_req(32'h0000_0200, 4'hF, 4'h0, 32'h0, 1'b1);
        do_req(32'h0000_0200, 4'hF, 4'h0, 32'h0, 1'b0);
        check("flush_fill", last_rdata, mem[8'h80]);

        fixed_lat = -1;
        spurious_en = 1'b1;
        repeat (150) begin
            a = {22'h0, 4'h4, 3'(($urandom_range(0, 7))), 1'b0, 2'($urandom_range(0, 3))};
            r = $urandom_range(0, 9);
            if (r < 3 || r == 8) begin
                wm = 4'($urandom_range(1, 15)); rm = 4'($urandom_range(0, 15));
            end else begin
                wm = 4'h0; rm = 4'($urandom_range(1, 15));
            end
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            do_req(a, rm, wm, $urandom, (r >= 8));
        end
        spurious_en = 1'b0;

        // Reset in the middle of a store's downstream wait.
        repeat (3) begin @(posedge clk); #1; end
        fixed_lat = 3;
        exp_m_read = 1'b0; exp_m_addr = 32'h0000_0140;
        exp_m_wmask = 4'b1000; exp_m_wdata = 32'h5500_0000;
        addr = 32'h0000_0140; rmask = 4'h0; wmask = 4'b1000; wdata = 32'h5500_0000;
        @(posedge clk); #1;
        check("pre_rst_mem_write", {31'h0, m_write}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_write", {31'h0, m_write}, 32'h0);
        check("async_rst_mem_read", {31'h0, m_read}, 32'h0);
        wmask = 4'h0;
        ref_buf_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_rst_no_resp", {31'h0, resp}, 32'h0);
        end
        fixed_lat = 1;
        do_req({22'h0, ref_buf_w[7:0], 2'b00}, 4'hF, 4'h0, 32'h0, 1'b0);

        nb_load();
        nb_load();
        check("nb_two_reads", nb_reads, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
